// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end controller for the combinational datapath ALU.
// Decodes one instruction slice into ALU operands/select, captures the ALU
// result and zero flag, resolves BEQ/BNE, and hands the result downstream
// over a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int Bits = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [Bits-1:0] rs1_val,
  input  logic [Bits-1:0] rs2_val,
  input  logic [Bits-1:0] imm,
  output logic [Bits-1:0] alu_a,
  output logic [Bits-1:0] alu_b,
  output logic [1:0]      alu_sel,
  input  logic [Bits-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Bits-1:0] out_result,
  output logic            out_zero,
  output logic            branch_taken,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  // What the EXEC stage must do with the ALU outputs.
  typedef enum logic [1:0] {K_ALU, K_BEQ, K_BNE, K_ILL} kind_t;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t          state;
  kind_t           kind;
  kind_t           dec_kind;
  logic [1:0]      dec_sel;
  logic [Bits-1:0] dec_b;
  logic            accept;

  // Ready is a pure function of state and downstream ready, never of in_valid.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Instruction decode into ALU select, operand B source and result handling.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dec_sel  = SEL_ADD;
    dec_b    = rs2_val;
    dec_kind = K_ILL;
    unique case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin dec_sel = SEL_ADD; dec_kind = K_ALU; end
            3'b111:  begin dec_sel = SEL_AND; dec_kind = K_ALU; end
            3'b110:  begin dec_sel = SEL_OR;  dec_kind = K_ALU; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_sel  = SEL_SUB;
          dec_kind = K_ALU;
        end
      end
      OP_I: begin
        case (funct3)
          3'b000:  begin dec_sel = SEL_ADD; dec_b = imm; dec_kind = K_ALU; end
          3'b111:  begin dec_sel = SEL_AND; dec_b = imm; dec_kind = K_ALU; end
          3'b110:  begin dec_sel = SEL_OR;  dec_b = imm; dec_kind = K_ALU; end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == 3'b011) begin
          dec_sel  = SEL_ADD;
          dec_b    = imm;
          dec_kind = K_ALU;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  begin dec_sel = SEL_SUB; dec_kind = K_BEQ; end
          3'b001:  begin dec_sel = SEL_SUB; dec_kind = K_BNE; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Issue FSM: latch operands on accept, capture ALU outputs in EXEC, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      kind         <= K_ALU;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= SEL_ADD;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      if (accept) begin
        alu_a   <= rs1_val;
        alu_b   <= dec_b;
        alu_sel <= dec_sel;
        kind    <= dec_kind;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          out_result   <= (kind == K_ILL) ? '0 : alu_result;
          out_zero     <= (kind != K_ILL) & alu_zero;
          branch_taken <= ((kind == K_BEQ) & alu_zero) |
                          ((kind == K_BNE) & ~alu_zero);
          illegal      <= (kind == K_ILL);
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a scoreboard queue of expected results.
module tb_alu_issue_ctrl;

  localparam int Bits = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [Bits-1:0] rs1_val, rs2_val, imm;
  logic [Bits-1:0] alu_a, alu_b;
  logic [1:0]      alu_sel;
  logic [Bits-1:0] alu_result;
  logic            alu_zero;
  logic            out_valid;
  logic            out_ready;
  logic [Bits-1:0] out_result;
  logic            out_zero;
  logic            branch_taken;
  logic            illegal;

  typedef struct {
    logic [1:0]      sel;
    logic [Bits-1:0] res;
    logic            zero;
    logic            taken;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.Bits(Bits)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  // Environment ALU driven from the DUT's registered operands.
  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [Bits-1:0] obs, input logic [Bits-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [Bits-1:0] a, input logic [Bits-1:0] b, input logic [Bits-1:0] im);
    opcode = opc; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [Bits-1:0] res,
                      input logic zero, input logic taken, input logic ill);
    exp_t e;
    e.sel = sel; e.res = res; e.zero = zero; e.taken = taken; e.ill = ill;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with the presented result.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_out_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_alu_sel"},      alu_sel,      e.sel);
      chk({tag, "_out_result"},   out_result,   e.res);
      chk({tag, "_out_zero"},     out_zero,     e.zero);
      chk({tag, "_branch_taken"}, branch_taken, e.taken);
      chk({tag, "_illegal"},      illegal,      e.ill);
    end
  endtask

  // Called #1 after the accept edge: DUT is in EXEC, result one edge later.
  task automatic post_accept(input string tag);
    in_valid = 1'b0;
    chk({tag, "_exec_no_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  task automatic run_one(input string tag,
                         input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [Bits-1:0] a, input logic [Bits-1:0] b, input logic [Bits-1:0] im,
                         input logic [1:0] sel, input logic [Bits-1:0] res,
                         input logic zero, input logic taken, input logic ill);
    @(negedge clk);
    drive(opc, f3, f7, a, b, im);
    push(sel, res, zero, taken, ill);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    post_accept(tag);
    drain(tag);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    // Reset with a valid add held at the input.
    drive(7'b0110011, 3'b000, 7'b0000000, 64'd5, 64'd7, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {branch_taken, illegal, out_zero, alu_sel}, 0);
    chk("rst_in_ready", in_ready, 1);

    // First edge after release accepts the held add.
    @(negedge clk);
    rst = 1'b0;
    push(2'b00, 64'd12, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("add_alu_a", alu_a, 64'd5);
    chk("add_alu_b", alu_b, 64'd7);
    post_accept("add");
    drain("add");

    run_one("sub_wrap", 7'b0110011, 3'b000, 7'b0100000, 64'd0, 64'd1, 64'd0,
            2'b01, {Bits{1'b1}}, 1'b0, 1'b0, 1'b0);
    run_one("addi_zero", 7'b0010011, 3'b000, 7'b1111111, 64'd3, 64'd99, -64'sd3,
            2'b00, 64'd0, 1'b1, 1'b0, 1'b0);
    run_one("beq", 7'b1100011, 3'b000, 7'b0000000, 64'd9, 64'd9, 64'd0,
            2'b01, 64'd0, 1'b1, 1'b1, 1'b0);
    run_one("bne", 7'b1100011, 3'b001, 7'b0000000, 64'd9, 64'd9, 64'd0,
            2'b01, 64'd0, 1'b1, 1'b0, 1'b0);
    run_one("ori", 7'b0010011, 3'b110, 7'b0000000, 64'hF0, 64'd0, 64'h0F,
            2'b11, 64'hFF, 1'b0, 1'b0, 1'b0);
    run_one("ld_addr", 7'b0000011, 3'b011, 7'b0000000, 64'h100, 64'd0, 64'd8,
            2'b00, 64'h108, 1'b0, 1'b0, 1'b0);

    // Backpressure: AND result held for 4 cycles, then a back-to-back accept.
    @(negedge clk);
    drive(7'b0110011, 3'b111, 7'b0000000, 64'hFF00, 64'h0FF0, 64'd0);
    push(2'b10, 64'h0F00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    post_accept("and_bp");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 64'h0F00);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    drive(7'b0010011, 3'b111, 7'b0000000, 64'hF, 64'd0, 64'h3C);
    push(2'b10, 64'hC, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("andi_alu_b", alu_b, 64'h3C);
    post_accept("andi_b2b");
    drain("andi_b2b");

    // Illegal instructions: result and zero forced low.
    run_one("illegal_lui", 7'b0110111, 3'b000, 7'b0000000, 64'd4, 64'd4, 64'd0,
            2'b00, 64'd0, 1'b0, 1'b0, 1'b1);
    run_one("illegal_zero", 7'b0110011, 3'b001, 7'b0000000, 64'd0, 64'd0, 64'd0,
            2'b00, 64'd0, 1'b0, 1'b0, 1'b1);

    // Reset during EXEC discards the in-flight add.
    @(negedge clk);
    drive(7'b0110011, 3'b000, 7'b0000000, 64'd20, 64'd22, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_exec_alu_a", alu_a, 0);
    chk("rst_exec_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_exec_no_pulse", out_valid, 0);
      chk("rst_exec_result", out_result, 0);
      chk("rst_exec_idle", in_ready, 1);
    end

    run_one("recover_add", 7'b0110011, 3'b000, 7'b0000000, 64'd20, 64'd22, 64'd0,
            2'b00, 64'd42, 1'b0, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Front-end controller for the RISC-V datapath's combinational ALU.
- Accepts one decoded instruction slice (opcode/funct fields plus operand values) over a valid/ready handshake.
- Translates it into the ALU's 2-bit operation select (00 add, 01 sub, 10 and, 11 or) and registered operands.
- Captures the ALU result and zero flag, resolves BEQ/BNE branch outcome, and presents everything downstream over a second valid/ready handshake.

## Interface

Parameters:
- Bits, 64, datapath width of operands and result

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept an instruction this cycle
- opcode  input  7  instruction bits [6:0]
- funct3  input  3  instruction bits [14:12]
- funct7  input  7  instruction bits [31:25]
- rs1_val  input  Bits  source register 1 value
- rs2_val  input  Bits  source register 2 value
- imm  input  Bits  sign-extended immediate
- alu_a  output  Bits  ALU operand A (registered)
- alu_b  output  Bits  ALU operand B (registered)
- alu_sel  output  2  ALU operation select (registered)
- alu_result  input  Bits  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_zero  input  1  ALU zero flag
- out_valid  output  1  result valid to downstream
- out_ready  input  1  downstream accepts result
- out_result  output  Bits  captured result
- out_zero  output  1  captured zero flag
- branch_taken  output  1  branch resolved taken
- illegal  output  1  instruction not supported

## Operation

Decode (alu_a = rs1_val always):
- R-type 0110011, funct7 0000000:
  - funct3 000 add: sel 00, B=rs2
  - funct3 111 and: sel 10, B=rs2
  - funct3 110 or: sel 11, B=rs2
- R-type 0110011, funct7 0100000, funct3 000 sub: sel 01, B=rs2
- I-type 0010011 (funct7 ignored):
  - funct3 000 addi: sel 00, B=imm
  - funct3 111 andi: sel 10, B=imm
  - funct3 110 ori: sel 11, B=imm
- Load 0000011 funct3 011 / store 0100011 funct3 011 (address calc): sel 00, B=imm
- Branch 1100011, sel 01, B=rs2:
  - funct3 000 beq: taken = alu_zero
  - funct3 001 bne: taken = !alu_zero
- Anything else: illegal=1, sel 00, B=rs2.
  - out_result forced 0, out_zero 0, branch_taken 0.
- branch_taken is 0 for every non-branch instruction.

FSM states:
- IDLE (reset state)
  - in_valid -> latch decode into alu_a/alu_b/alu_sel and an internal kind register; go EXEC.
- EXEC
  - Unconditionally capture alu_result/alu_zero/branch_taken/illegal into output registers, set out_valid; go DONE.
- DONE
  - Hold all outputs stable while out_ready=0.
  - out_ready=1 and in_valid=1: accept the new instruction this edge; go EXEC.
  - out_ready=1 and in_valid=0: go IDLE, out_valid=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational, no dependence on in_valid.
- alu_a/alu_b/alu_sel change only on an accept edge and are otherwise held.
- Arithmetic is performed by the ALU at Bits width, wrap-around; this block does no arithmetic.

## Timing

- Reset values (immediate, asynchronous): state IDLE, alu_a 0, alu_b 0, alu_sel 00, out_result 0, out_zero 0, branch_taken 0, illegal 0, out_valid 0. in_ready 1 one delta after reset.
- Latency: instruction accepted at edge N -> out_valid high after edge N+1.
- Throughput: one instruction per 2 cycles with out_ready held high.
- Output registers change only at the EXEC->DONE edge.
- Reset asserted mid-operation (EXEC or DONE): in-flight instruction is discarded, all outputs return to reset values, and no out_valid pulse is emitted.
- out_ready while out_valid=0 has no effect.

## Test plan

- Reset with in_valid=1 held: all outputs 0, in_ready=1, no accept until rst low. First edge after release accepts.
- Add: rs1=5, rs2=7, opcode 0110011, funct3 000, funct7 0 -> alu_sel 00, out_result 12, out_zero 0, out_valid one cycle after accept.
- Sub wrap-around: rs1=0, rs2=1, funct7 0100000 -> out_result all ones (2^Bits-1), out_zero 0. Then addi rs1=3, imm=-3 -> out_result 0, out_zero 1.
- BEQ rs1=rs2=9 -> alu_sel 01, branch_taken 1. BNE with the same operands -> branch_taken 0. Ori rs1=0xF0, imm=0x0F -> 0xFF, branch_taken 0.
- Backpressure: hold out_ready=0 for 4 cycles -> outputs stable, in_ready 0. Raise out_ready together with in_valid -> next instruction accepted that edge and its result appears one cycle later.
- Illegal: opcode 0110111 -> illegal 1, out_result 0, out_zero 0. Assert rst during EXEC of a valid add -> out_valid never rises and state returns to IDLE.
